// File: rtl/dff_bank_pkg.sv
// Shared op codes, state encoding and default width for the DFF bank sequencer.
package dff_bank_pkg;

    localparam int unsigned W_DEFAULT = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_PULSE   = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/dff_bank_timer.sv
// Loadable down-counter timing the PULSE and RECOVER phases; saturates at zero.
module dff_bank_timer #(
    parameter int unsigned TW = 1
) (
    input  logic          clk,
    input  logic          R,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic [TW-1:0] value,
    output logic          zero
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (R) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/dff_bank_seq.sv
// Command sequencer driving a shared-control DFF bank (D, S_n, R_n, capture enable).
// Optional readback check enabled by defining DFF_BANK_SEQ_VERIFY_EN (adds err port).
module dff_bank_seq
    import dff_bank_pkg::*;
#(
    parameter int unsigned W         = W_DEFAULT,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned REC_CYC   = 1
) (
    input  logic         clk,
    input  logic         R,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic         ser_in,
    input  logic [W-1:0] ff_q,
    output logic [W-1:0] ff_d,
    output logic         ff_s_n,
    output logic         ff_r_n,
    output logic         ff_en,
    output logic         busy,
    output logic         done
`ifdef DFF_BANK_SEQ_VERIFY_EN
    ,
    output logic         err
`endif
);

    localparam int unsigned TMAX = (PULSE_CYC > REC_CYC) ? PULSE_CYC : REC_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   ff_d_q, ff_d_d;
    logic           ff_s_n_q, ff_s_n_d;
    logic           ff_r_n_q, ff_r_n_d;
    logic           ff_en_q, ff_en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cmd_ready_q, cmd_ready_d;

    logic           tmr_load;
    logic [TW-1:0]  tmr_load_val;
    logic           tmr_dec;
    logic [TW-1:0]  tmr_value;
    logic           tmr_zero;

    dff_bank_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .R        (R),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ff_d_d       = ff_d_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    if (cmd_op == OP_LOAD) begin
                        ff_d_d  = cmd_data;
                        state_d = ST_CAPTURE;
                    end else if (cmd_op == OP_SHIFT) begin
                        ff_d_d  = W'({ff_q, ser_in});
                        state_d = ST_CAPTURE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = TW'(PULSE_CYC - 1);
                        state_d      = ST_PULSE;
                    end
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_PULSE: begin
                if (tmr_zero) begin
                    if (REC_CYC != 0) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = TW'((REC_CYC != 0) ? REC_CYC - 1 : 0);
                        state_d      = ST_RECOVER;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_dec = (tmr_value != '0);
                end
            end
            ST_RECOVER: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = (tmr_value != '0);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        ff_en_d     = (state_d == ST_CAPTURE);
        ff_s_n_d    = !((state_d == ST_PULSE) && (op_d == OP_SET));
        ff_r_n_d    = !((state_d == ST_PULSE) && (op_d == OP_CLR));
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            ff_d_q      <= '0;
            ff_s_n_q    <= 1'b1;
            ff_r_n_q    <= 1'b1;
            ff_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ff_d_q      <= ff_d_d;
            ff_s_n_q    <= ff_s_n_d;
            ff_r_n_q    <= ff_r_n_d;
            ff_en_q     <= ff_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ff_d      = ff_d_q;
    assign ff_s_n    = ff_s_n_q;
    assign ff_r_n    = ff_r_n_q;
    assign ff_en     = ff_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef DFF_BANK_SEQ_VERIFY_EN
    // Readback compare in the DONE cycle; err follows the miscompare immediately, then sticks
    logic [W-1:0] exp_c;
    logic         miscmp_c;
    logic         err_q;

    always_comb begin
        exp_c = ff_d_q;
        if (op_q == OP_SET) begin
            exp_c = '1;
        end else if (op_q == OP_CLR) begin
            exp_c = '0;
        end
        miscmp_c = done_q && (ff_q != exp_c);
    end

    always_ff @(posedge clk) begin
        if (R) begin
            err_q <= 1'b0;
        end else if (miscmp_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q | miscmp_c;
`endif

endmodule

// File: tb/tb_dff_bank_seq.sv
// Scoreboard bench for dff_bank_seq with an attached behavioural DFF bank.
module tb_dff_bank_seq;
    import dff_bank_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned P  = 2;
    localparam int unsigned RC = 1;

    logic         clk = 1'b0;
    logic         R;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         ser_in;
    logic [W-1:0] ff_q;
    logic [W-1:0] ff_d;
    logic         ff_s_n, ff_r_n, ff_en, busy, done;
`ifdef DFF_BANK_SEQ_VERIFY_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    dff_bank_seq #(.W(W), .PULSE_CYC(P), .REC_CYC(RC)) dut (
        .clk       (clk),
        .R         (R),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .ser_in    (ser_in),
        .ff_q      (ff_q),
        .ff_d      (ff_d),
        .ff_s_n    (ff_s_n),
        .ff_r_n    (ff_r_n),
        .ff_en     (ff_en),
        .busy      (busy),
        .done      (done)
`ifdef DFF_BANK_SEQ_VERIFY_EN
        ,
        .err       (err)
`endif
    );

    // Register bank with async active-low set/clear; stuck0 models a faulty bit 0
    logic [W-1:0] bank_q;
    logic         stuck0 = 1'b0;
    always @(posedge clk or negedge ff_s_n or negedge ff_r_n) begin
        if (!ff_s_n)      bank_q <= '1;
        else if (!ff_r_n) bank_q <= '0;
        else if (ff_en)   bank_q <= ff_d;
    end
    assign ff_q = stuck0 ? {bank_q[W-1:1], 1'b0} : bank_q;

    typedef struct packed {
        logic [W-1:0] val;
        int unsigned  due;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] model;
    int unsigned  cyc = 0;
    int           vec_cnt = 0;
    int           err_cnt = 0;
    logic         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: runs at each accepted command, predicts final bank value and done cycle
    task automatic predictor();
        forever begin
            @(posedge clk);
            if (R) begin
                sbq.delete();
            end else if (cmd_valid && cmd_ready) begin
                exp_t e;
                case (cmd_op)
                    OP_LOAD:  model = cmd_data;
                    OP_SHIFT: model = {model[W-2:0], ser_in};
                    OP_SET:   model = '1;
                    default:  model = '0;
                endcase
                e.val = stuck0 ? {model[W-1:1], 1'b0} : model;
                e.due = cyc + ((cmd_op == OP_LOAD || cmd_op == OP_SHIFT) ? 2 : 1 + P + RC);
                sbq.push_back(e);
            end
            cyc++;
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on done, pulse-width measurement
    task automatic monitor();
        int s_cnt = 0;
        int r_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!chk_en || R) begin
                s_cnt = 0;
                r_cnt = 0;
            end else begin
                check("inv_setclr_both_low", 32'(!ff_s_n && !ff_r_n), 32'd0);
                check("inv_en_during_async", 32'(ff_en && (!ff_s_n || !ff_r_n)), 32'd0);
                check("inv_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e = sbq.pop_front();
                        check("done_ff_q", 32'(ff_q), 32'(e.val));
                        check("done_latency", cyc, e.due);
                    end
                end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
                    check("done_timeout", cyc, sbq[0].due);
                    void'(sbq.pop_front());
                end
                if (!ff_s_n) s_cnt++;
                else if (s_cnt != 0) begin
                    check("set_pulse_width", 32'(s_cnt), 32'(P));
                    s_cnt = 0;
                end
                if (!ff_r_n) r_cnt++;
                else if (r_cnt != 0) begin
                    check("clr_pulse_width", 32'(r_cnt), 32'(P));
                    r_cnt = 0;
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic s);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("send_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        ser_in    = s;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = W'($urandom);
        ser_in    = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    logic [W-1:0] shift_exp [4];
    logic         shift_ser [4];

    initial begin
        R = 1'b1; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_data = '0; ser_in = 1'b0;
        model = '0;
        fork
            predictor();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s_n", 32'(ff_s_n), 32'd1);
        check("rst_r_n", 32'(ff_r_n), 32'd1);
        check("rst_en", 32'(ff_en), 32'd0);
        check("rst_ff_d", 32'(ff_d), 32'd0);
        R = 1'b0;
        chk_en = 1'b1;

        send(OP_CLR, '0, 1'b0);
        wait_done("init_clr_done");

        // Reset in the middle of a SET_ALL pulse
        send(OP_SET, '0, 1'b0);
        check("abort_s_n_low", 32'(ff_s_n), 32'd0);
        R = 1'b1;
        @(negedge clk);
        check("abort_s_n_released", 32'(ff_s_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        R = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_ff_q_kept", 32'(ff_q), 32'hF);

        // LOAD timing
        send(OP_LOAD, 4'b1010, 1'b0);
        check("load_en_t1", 32'(ff_en), 32'd1);
        check("load_ff_d_t1", 32'(ff_d), 32'hA);
        check("load_ready_t1", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("load_done_t2", 32'(done), 32'd1);
        check("load_en_t2", 32'(ff_en), 32'd0);
        check("load_ready_t2", 32'(cmd_ready), 32'd0);
        check("load_ff_q", 32'(ff_q), 32'hA);
        @(negedge clk);
        check("load_ready_t3", 32'(cmd_ready), 32'd1);
        check("load_done_t3", 32'(done), 32'd0);

        // SET_ALL then CLEAR_ALL cycle-by-cycle
        for (int op = 0; op < 2; op++) begin
            send(op == 0 ? OP_SET : OP_CLR, '0, 1'b0);
            for (int k = 1; k <= 4; k++) begin
                if (k > 1) @(negedge clk);
                check(op == 0 ? "set_s_n" : "clr_r_n",
                      32'(op == 0 ? ff_s_n : ff_r_n), 32'(k > 2));
                check(op == 0 ? "set_r_n" : "clr_s_n",
                      32'(op == 0 ? ff_r_n : ff_s_n), 32'd1);
                check("async_done", 32'(done), 32'(k == 4));
            end
            check("async_ff_q", 32'(ff_q), op == 0 ? 32'hF : 32'h0);
        end

        // SHIFT sequence from zero
        shift_ser = '{1'b1, 1'b0, 1'b1, 1'b1};
        shift_exp = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        for (int i = 0; i < 4; i++) begin
            send(OP_SHIFT, W'($urandom), shift_ser[i]);
            wait_done("shift_done");
            check("shift_ff_q", 32'(ff_q), 32'(shift_exp[i]));
        end

        // Randomized traffic with cmd_valid often held high across busy periods
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom);
            cmd_data  = W'($urandom);
            ser_in    = 1'($urandom);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

`ifdef DFF_BANK_SEQ_VERIFY_EN
        check("err_clean", 32'(err), 32'd0);
        stuck0 = 1'b1;
        send(OP_LOAD, 4'b0001, 1'b0);
        wait_done("stuck_done");
        check("err_on_done", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        R = 1'b1;
        @(negedge clk);
        check("err_reset", 32'(err), 32'd0);
        R = 1'b0;
        stuck0 = 1'b0;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dff_bank_seq.md
Name: dff_bank_seq

Overview:
- Command-driven sequencer for a bank of W D flip-flop cells that share common active-low set, active-low clear, data and capture-enable lines.
- Accepts one op at a time (LOAD, SHIFT, SET_ALL, CLEAR_ALL) over a valid/ready handshake.
- Drives the cells' D, S_n, R_n and capture-enable lines with guaranteed pulse-width and recovery timing.
- Sits between the system control logic and the register bank; it is the only driver of the bank's control pins.

Parameters:
- W, 4, bank width in bits (>=2)
- PULSE_CYC, 2, cycles the async set/clear line is held low (>=1)
- REC_CYC, 1, recovery cycles after set/clear release before done (>=0; 0 skips RECOVER)

Ports:
- clk  in  1  system clock, rising edge
- R  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  2  00 LOAD, 01 SHIFT, 10 SET_ALL, 11 CLEAR_ALL
- cmd_data  in  W  LOAD value
- ser_in  in  1  SHIFT serial input (LSB side)
- ff_q  in  W  bank Q outputs
- ff_d  out  W  bank D inputs
- ff_s_n  out  1  bank async set, active-low
- ff_r_n  out  1  bank async clear, active-low
- ff_en  out  1  bank capture enable; bank captures ff_d at the clk edge ending a cycle with ff_en=1
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse on op completion

Behaviour:
- Reset (R=1 at a rising edge): state=IDLE, ff_d=0, ff_s_n=1, ff_r_n=1, ff_en=0, busy=0, done=0, timer=0.
- Reset mid-operation aborts immediately. Set/clear lines release on that same edge, and no done is issued.
- States: IDLE, CAPTURE, PULSE, RECOVER, DONE.
- IDLE: cmd_ready=1. A handshake occurs when cmd_valid=1 at a rising edge. The op and operands are registered and cmd_data is ignored afterwards.
  - LOAD or SHIFT: go to CAPTURE.
  - SET_ALL or CLEAR_ALL: go to PULSE with timer=PULSE_CYC-1.
- CAPTURE (exactly 1 cycle): ff_en=1.
  - LOAD: ff_d = registered cmd_data.
  - SHIFT: ff_d = {ff_q[W-2:0], ser_in}, with ser_in sampled at the handshake edge.
  - Next state: DONE.
- PULSE: SET_ALL drives ff_s_n=0; CLEAR_ALL drives ff_r_n=0. Hold for exactly PULSE_CYC cycles (timer counts down to 0). Then go to RECOVER if REC_CYC>0, else DONE.
- RECOVER: ff_s_n=ff_r_n=1 and ff_en=0 for exactly REC_CYC cycles, then go to DONE.
- DONE (1 cycle): done=1, busy=1, cmd_ready=0. Next state: IDLE.
- Latency from the handshake edge to the done cycle:
  - LOAD/SHIFT: done in cycle T+2.
  - SET/CLEAR: done in cycle T+1+PULSE_CYC+REC_CYC.
- Invariants (assert in bench):
  - ff_s_n and ff_r_n are never both 0.
  - ff_en is never 1 while either ff_s_n or ff_r_n is 0.
  - All outputs are registered, with no glitches.
- cmd_valid held high while busy: no acceptance and no side effect. The next command is accepted in the IDLE cycle after DONE, giving a back-to-back spacing of 3 cycles minimum for LOAD.
- Timer width is clog2(max(PULSE_CYC,REC_CYC)+1) and counts down. Reaching 0 ends the state; it never wraps.

Optional Feature:
- Macro: DFF_BANK_SEQ_VERIFY_EN.
- With the macro defined:
  - Adds output port err (1 bit, reset 0, sticky until R).
  - In the DONE cycle, ff_q is compared to the expected value: LOAD gives cmd_data, SHIFT gives the computed ff_d, SET_ALL gives all-ones, CLEAR_ALL gives all-zeros.
  - A mismatch sets err in the same cycle that done is high.
- Without the macro: no err port and no compare logic; timing is identical.

Decomposition:
- Package dff_bank_pkg holds:
  - the op code constants (OP_LOAD=2'b00, OP_SHIFT=2'b01, OP_SET=2'b10, OP_CLR=2'b11);
  - the state encoding constants;
  - the W default.
- One sub-module, dff_bank_timer: a loadable down-counter with load, value and zero outputs, shared by PULSE and RECOVER.

Test Plan (W=4, PULSE_CYC=2, REC_CYC=1, real DFF bank model attached):
- Assert R for 2 cycles mid-SET_ALL pulse -> ff_s_n=1 on the reset edge, busy=0, no done, ff_q unchanged after release.
- LOAD 4'b1010 -> ff_en high 1 cycle at T+1, done at T+2, ff_q=1010; cmd_ready low T+1..T+2.
- SET_ALL -> ff_s_n low exactly 2 cycles, 1 recovery cycle, done at T+4, ff_q=1111. Then CLEAR_ALL -> ff_r_n low 2 cycles, ff_q=0000.
- SHIFT ×4 with ser_in=1,0,1,1 from ff_q=0000 -> ff_q = 0001, 0010, 0101, 1011.
- Hold cmd_valid high continuously, alternating ops -> each accepted only in IDLE. Invariant checks on ff_s_n/ff_r_n/ff_en pass every cycle.
- VERIFY_EN defined: force ff_q bit0 stuck at 0, LOAD 4'b0001 -> err=1 with done and stays 1 until R.
